// File: rtl/gty_prbs31_rx_checker_if.sv
// RX-side bundle for the PRBS31 checker: received word, qualifier, counter clear and BER status.
interface gty_prbs31_rx_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 48
);
  logic [DATA_WIDTH-1:0] rx_data_i;
  logic                  rx_valid_i;
  logic                  cnt_clear_i;
  logic                  locked_o;
  logic                  err_pulse_o;
  logic [CNT_WIDTH-1:0]  err_cnt_o;
  logic [CNT_WIDTH-1:0]  word_cnt_o;

  modport master (
    output rx_data_i, rx_valid_i, cnt_clear_i,
    input  locked_o, err_pulse_o, err_cnt_o, word_cnt_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, cnt_clear_i,
    output locked_o, err_pulse_o, err_cnt_o, word_cnt_o
  );
endinterface

// File: rtl/gty_prbs31_rx_checker.sv
// PRBS31 (x^31+x^28+1) receive checker: self-synchronising seed/verify, then free-running
// LFSR comparison with saturating bit-error and word counters.
module gty_prbs31_rx_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH    = 48,
  parameter bit INVERT       = 1'b0
) (
  input logic                     clk,
  input logic                     rst_n,
  gty_prbs31_rx_checker_if.slave  bus
);

  localparam int NERR_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // lfsr[30] is the newest bit; bit k of the result is the k-th bit on the wire after the seed.
  function automatic logic [DATA_WIDTH-1:0] prbs_next(input logic [30:0] seed);
    logic [DATA_WIDTH+30:0] ext;
    ext       = '0;
    ext[30:0] = seed;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      ext[k+31] = ext[k] ^ ext[k+3];
    end
    return ext[DATA_WIDTH+30:31];
  endfunction

  function automatic logic [NERR_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [NERR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cnt = cnt + NERR_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t                 state_r, state_s;
  logic [30:0]            lfsr_r, lfsr_s;
  logic [7:0]             good_cnt_r, good_cnt_s;
  logic [7:0]             bad_cnt_r, bad_cnt_s;
  logic                   locked_r;
  logic                   err_pulse_r, err_pulse_s;
  logic [CNT_WIDTH-1:0]   err_cnt_r, err_cnt_s;
  logic [CNT_WIDTH-1:0]   word_cnt_r, word_cnt_s;
  logic [DATA_WIDTH-1:0]  data_s;
  logic [DATA_WIDTH-1:0]  expected_s;
  logic [NERR_W-1:0]      nerr_s;
  logic [CNT_WIDTH:0]     err_sum_s;

  // Next-state, LFSR, lock/unlock counters and saturating BER counters.
  always_comb begin
    data_s      = INVERT ? ~bus.rx_data_i : bus.rx_data_i;
    expected_s  = prbs_next(lfsr_r);
    nerr_s      = popcount(data_s ^ expected_s);
    err_sum_s   = {1'b0, err_cnt_r} + (CNT_WIDTH + 1)'(nerr_s);
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    good_cnt_s  = good_cnt_r;
    bad_cnt_s   = bad_cnt_r;
    err_pulse_s = 1'b0;
    err_cnt_s   = err_cnt_r;
    word_cnt_s  = word_cnt_r;
    if (bus.rx_valid_i) begin
      case (state_r)
        SEED: begin
          lfsr_s     = data_s[DATA_WIDTH-1 -: 31];
          good_cnt_s = 8'd0;
          state_s    = VERIFY;
        end
        VERIFY: begin
          lfsr_s = data_s[DATA_WIDTH-1 -: 31];
          if (nerr_s == '0) begin
            if (({1'b0, good_cnt_r} + 9'd1) == 9'(LOCK_COUNT)) begin
              state_s    = LOCKED;
              bad_cnt_s  = 8'd0;
              good_cnt_s = 8'd0;
            end else begin
              good_cnt_s = good_cnt_r + 8'd1;
            end
          end else begin
            good_cnt_s = 8'd0;
          end
        end
        LOCKED: begin
          // Free-run from the prediction so a flipped bit is counted once, not three times.
          lfsr_s     = expected_s[DATA_WIDTH-1 -: 31];
          word_cnt_s = (word_cnt_r == {CNT_WIDTH{1'b1}}) ? word_cnt_r : word_cnt_r + CNT_WIDTH'(1);
          err_cnt_s  = err_sum_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : err_sum_s[CNT_WIDTH-1:0];
          if (nerr_s != '0) begin
            err_pulse_s = 1'b1;
            bad_cnt_s   = bad_cnt_r + 8'd1;
            if (({1'b0, bad_cnt_r} + 9'd1) == 9'(UNLOCK_COUNT)) begin
              state_s = SEED;
            end else begin
              state_s = LOCKED;
            end
          end else begin
            bad_cnt_s = 8'd0;
          end
        end
        default: begin
          state_s = SEED;
        end
      endcase
    end else begin
      err_pulse_s = 1'b0;
    end
    if (bus.cnt_clear_i) begin
      err_cnt_s  = '0;
      word_cnt_s = '0;
    end else begin
      err_cnt_s  = err_cnt_s;
      word_cnt_s = word_cnt_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= SEED;
      lfsr_r      <= 31'd0;
      good_cnt_r  <= 8'd0;
      bad_cnt_r   <= 8'd0;
      locked_r    <= 1'b0;
      err_pulse_r <= 1'b0;
      err_cnt_r   <= '0;
      word_cnt_r  <= '0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      good_cnt_r  <= good_cnt_s;
      bad_cnt_r   <= bad_cnt_s;
      locked_r    <= (state_s == LOCKED);
      err_pulse_r <= err_pulse_s;
      err_cnt_r   <= err_cnt_s;
      word_cnt_r  <= word_cnt_s;
    end
  end

  assign bus.locked_o    = locked_r;
  assign bus.err_pulse_o = err_pulse_r;
  assign bus.err_cnt_o   = err_cnt_r;
  assign bus.word_cnt_o  = word_cnt_r;

endmodule

// File: tb/tb_gty_prbs31_rx_checker.sv
// Directed bench for gty_prbs31_rx_checker: main instance, an 8-bit-counter instance for
// saturation and an INVERT=1 instance fed the complemented stream.
module tb_gty_prbs31_rx_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gty_prbs31_rx_checker_if #(.DATA_WIDTH(64), .CNT_WIDTH(48)) bus_m ();
  gty_prbs31_rx_checker_if #(.DATA_WIDTH(64), .CNT_WIDTH(8))  bus_s ();
  gty_prbs31_rx_checker_if #(.DATA_WIDTH(64), .CNT_WIDTH(48)) bus_i ();

  gty_prbs31_rx_checker #(.DATA_WIDTH(64), .CNT_WIDTH(48)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m));
  gty_prbs31_rx_checker #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  gty_prbs31_rx_checker #(.DATA_WIDTH(64), .CNT_WIDTH(48), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .bus(bus_i));

  typedef struct {
    logic        v;
    logic        clr;
    logic [63:0] mask;
    logic        locked;
    logic        pulse;
    logic [47:0] err;
    logic [47:0] word;
  } vec_t;

  vec_t        tbl[21];
  int          vectors    = 0;
  int          miscompares = 0;
  logic [30:0] hist = 31'h1234_5678;

  // Serial reference generator: b[n] = b[n-31] ^ b[n-28], bit 0 of the word first on the wire.
  task automatic gen_word(output logic [63:0] w);
    logic nb;
    for (int k = 0; k < 64; k++) begin
      nb   = hist[0] ^ hist[3];
      w[k] = nb;
      hist = {nb, hist[30:1]};
    end
  endtask

  task automatic drive(input logic v, input logic clr, input logic [63:0] mask);
    logic [63:0] w;
    @(negedge clk);
    if (v) begin
      gen_word(w);
      bus_m.rx_data_i = w ^ mask;
      bus_s.rx_data_i = w ^ mask;
      bus_i.rx_data_i = ~w;
    end else begin
      w = {$urandom, $urandom};
      bus_m.rx_data_i = w;
      bus_s.rx_data_i = w;
      bus_i.rx_data_i = w;
    end
    bus_m.rx_valid_i  = v;
    bus_s.rx_valid_i  = v;
    bus_i.rx_valid_i  = v;
    bus_m.cnt_clear_i = clr;
    bus_s.cnt_clear_i = clr;
    bus_i.cnt_clear_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int nvalid;
    logic v;

    tbl[0]  = '{1'b1, 1'b1, 64'h0,                   1'b1, 1'b0, 48'd0,  48'd0};
    tbl[1]  = '{1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd0,  48'd1};
    tbl[2]  = '{1'b1, 1'b0, 64'h20,                  1'b1, 1'b1, 48'd1,  48'd2};
    tbl[3]  = '{1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd1,  48'd2};
    tbl[4]  = '{1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd1,  48'd3};
    tbl[5]  = '{1'b1, 1'b0, 64'h7,                   1'b1, 1'b1, 48'd4,  48'd4};
    tbl[6]  = '{1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd4,  48'd5};
    tbl[7]  = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd5,  48'd6};
    tbl[8]  = '{1'b1, 1'b0, 64'h80,                  1'b1, 1'b1, 48'd6,  48'd7};
    tbl[9]  = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 48'd7,  48'd8};
    tbl[10] = '{1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd7,  48'd9};
    tbl[11] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd8,  48'd10};
    tbl[12] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd9,  48'd11};
    tbl[13] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd10, 48'd12};
    tbl[14] = '{1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 48'd10, 48'd13};
    tbl[15] = '{1'b1, 1'b1, 64'h0,                   1'b1, 1'b0, 48'd0,  48'd0};
    tbl[16] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd1,  48'd1};
    tbl[17] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd2,  48'd2};
    tbl[18] = '{1'b1, 1'b0, 64'h1,                   1'b1, 1'b1, 48'd3,  48'd3};
    tbl[19] = '{1'b1, 1'b0, 64'h1,                   1'b0, 1'b1, 48'd4,  48'd4};
    tbl[20] = '{1'b1, 1'b0, 64'h0,                   1'b0, 1'b0, 48'd4,  48'd4};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'h0);
    drive(1'b0, 1'b0, 64'h0);
    chk("rst_locked", 64'(bus_m.locked_o), 64'd0);
    chk("rst_pulse", 64'(bus_m.err_pulse_o), 64'd0);
    chk("rst_err_cnt", 64'(bus_m.err_cnt_o), 64'd0);
    chk("rst_word_cnt", 64'(bus_m.word_cnt_o), 64'd0);
    rst_n = 1'b1;

    // Acquire lock with roughly half the cycles idle; only valid words count.
    n = 0;
    nvalid = 0;
    while (!bus_m.locked_o && n < 300) begin
      v = 1'($urandom_range(0, 1));
      drive(v, 1'b0, 64'h0);
      if (v) nvalid++;
      n++;
    end
    chk("lock_valid_words", 64'(nvalid), 64'd17);
    chk("inv_locked", 64'(bus_i.locked_o), 64'd1);
    chk("lock_err_cnt", 64'(bus_m.err_cnt_o), 64'd0);
    chk("lock_word_cnt", 64'(bus_m.word_cnt_o), 64'd0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].clr, tbl[i].mask);
      chk($sformatf("vec%0d_locked", i), 64'(bus_m.locked_o), 64'(tbl[i].locked));
      chk($sformatf("vec%0d_pulse", i), 64'(bus_m.err_pulse_o), 64'(tbl[i].pulse));
      chk($sformatf("vec%0d_err", i), 64'(bus_m.err_cnt_o), 64'(tbl[i].err));
      chk($sformatf("vec%0d_word", i), 64'(bus_m.word_cnt_o), 64'(tbl[i].word));
    end

    // Word 20 reseeded; 16 verify words are needed to re-lock.
    n = 0;
    while (!bus_m.locked_o && n < 100) begin
      drive(1'b1, 1'b0, 64'h0);
      n++;
    end
    chk("relock_words", 64'(n), 64'd16);

    // Saturation: 33 words with 8 bit errors each, interleaved with clean words.
    drive(1'b1, 1'b1, 64'h0);
    for (int g = 0; g < 11; g++) begin
      for (int e = 0; e < 3; e++) drive(1'b1, 1'b0, 64'hFF);
      drive(1'b1, 1'b0, 64'h0);
    end
    chk("sat_main_err", 64'(bus_m.err_cnt_o), 64'd264);
    chk("sat_main_word", 64'(bus_m.word_cnt_o), 64'd44);
    chk("sat_small_err", 64'(bus_s.err_cnt_o), 64'd255);
    chk("sat_small_word", 64'(bus_s.word_cnt_o), 64'd44);
    chk("sat_small_locked", 64'(bus_s.locked_o), 64'd1);
    for (int k = 0; k < 260; k++) drive(1'b1, 1'b0, 64'h0);
    chk("sat_main_word2", 64'(bus_m.word_cnt_o), 64'd304);
    chk("sat_small_word2", 64'(bus_s.word_cnt_o), 64'd255);
    chk("sat_small_err2", 64'(bus_s.err_cnt_o), 64'd255);

    // Clear coinciding with an errored word.
    drive(1'b1, 1'b1, 64'hFF);
    chk("clr_err_main", 64'(bus_m.err_cnt_o), 64'd0);
    chk("clr_word_main", 64'(bus_m.word_cnt_o), 64'd0);
    chk("clr_err_small", 64'(bus_s.err_cnt_o), 64'd0);
    chk("clr_word_small", 64'(bus_s.word_cnt_o), 64'd0);
    chk("clr_pulse", 64'(bus_m.err_pulse_o), 64'd1);
    chk("clr_locked", 64'(bus_m.locked_o), 64'd1);
    chk("inv_still_locked", 64'(bus_i.locked_o), 64'd1);
    chk("inv_err_cnt", 64'(bus_i.err_cnt_o), 64'd0);

    drive(1'b1, 1'b0, 64'h3);
    chk("pre_rst_err", 64'(bus_m.err_cnt_o), 64'd2);
    chk("pre_rst_word", 64'(bus_m.word_cnt_o), 64'd1);

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 64'h0);
    chk("midrst_locked", 64'(bus_m.locked_o), 64'd0);
    chk("midrst_pulse", 64'(bus_m.err_pulse_o), 64'd0);
    chk("midrst_err", 64'(bus_m.err_cnt_o), 64'd0);
    chk("midrst_word", 64'(bus_m.word_cnt_o), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h0);
    chk("post_rst_seed_locked", 64'(bus_m.locked_o), 64'd0);
    chk("post_rst_seed_word", 64'(bus_m.word_cnt_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
